// File: rtl/seg7_pkg.sv
// Shared seven-segment patterns (g..a, active-high), converter FSM states
// and the nibble-to-segment lookup used by every digit decoder.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    UPDATE  = 2'd2
  } state_t;

  // Codes 10..15 never come out of a correct conversion; show them as dash.
  function automatic logic [6:0] digit_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_digit_dec.sv
// One BCD digit to seven-segment pattern (active-high); combinational, no backpressure.
// Dash overrides blank, blank overrides the digit value.
module seg7_digit_dec
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);

  always_comb begin
    seg = digit_to_seg(nibble);
    if (dash) begin
      seg = SEG_DASH;
    end else if (blank) begin
      seg = SEG_BLANK;
    end
  end

endmodule

// File: rtl/seg7_bcd_display.sv
// Binary to multi-digit seven-segment driver using a bit-serial double-dabble engine.
// Latency WIDTH+1 edges from accept to leds/done; in_ready is low while busy, no queueing.
module seg7_bcd_display #(
  parameter int WIDTH         = 8,
  parameter int DIGITS        = 3,
  parameter int ACTIVE_LOW    = 1,
  parameter int BLANK_LEADING = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  in_ready,
  output logic [DIGITS*7-1:0]   leds,
  output logic                  done,
  output logic                  overflow
);
  import seg7_pkg::*;

  localparam int              BW       = DIGITS * 4;
  localparam int              CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LAST     = CW'(WIDTH - 1);
  localparam logic [63:0]     MAX_VAL  = 64'(10 ** DIGITS) - 64'd1;
  localparam logic [DIGITS*7-1:0] LEDS_OFF = {(DIGITS*7){ACTIVE_LOW != 0}};

  state_t              state, state_nxt;
  logic                load, shift, update;
  logic [WIDTH-1:0]    shreg;
  logic [BW-1:0]       bcd, bcd_adj;
  logic [CW-1:0]       cnt;
  logic                ovf_pending;
  logic [DIGITS-1:0]   blank;
  logic                zero_run;
  logic [DIGITS*7-1:0] pat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;
    update    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = CONVERT;
        end
      end
      CONVERT: begin
        shift = 1'b1;
        if (cnt == LAST) state_nxt = UPDATE;
      end
      UPDATE: begin
        update    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Add-3 correction happens before the shift, so each nibble stays a valid BCD digit.
  always_comb begin
    bcd_adj = bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
    end
  end

  always_comb begin
    blank    = '0;
    zero_run = 1'b1;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      zero_run = zero_run & (bcd[4*d +: 4] == 4'd0);
      blank[d] = (BLANK_LEADING != 0) && (d != 0) && zero_run;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    seg7_digit_dec u_dec (
      .nibble (bcd[4*g +: 4]),
      .blank  (blank[g]),
      .dash   (ovf_pending),
      .seg    (pat[7*g +: 7])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg       <= '0;
      bcd         <= '0;
      cnt         <= '0;
      ovf_pending <= 1'b0;
      leds        <= LEDS_OFF;
      overflow    <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= update;
      if (load) begin
        shreg       <= in_data;
        bcd         <= '0;
        cnt         <= '0;
        ovf_pending <= 64'(in_data) > MAX_VAL;
      end else if (shift) begin
        bcd   <= BW'({bcd_adj, shreg[WIDTH-1]});
        shreg <= shreg << 1;
        cnt   <= cnt + CW'(1);
      end
      if (update) begin
        leds     <= (ACTIVE_LOW != 0) ? ~pat : pat;
        overflow <= ovf_pending;
      end
    end
  end

endmodule

// File: tb/tb_seg7_bcd_display.sv
// Bench for seg7_bcd_display: three configurations checked every cycle against a
// decimal-arithmetic display model, plus hand-computed pattern expectations.
module tb_seg7_bcd_display;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid0 = 1'b0;
  logic [7:0] in_data0  = '0;
  logic       in_valid2 = 1'b0;
  logic [9:0] in_data2  = '0;

  logic        rdy0, rdy1, rdy2, done0, done1, done2, ovf0, ovf1, ovf2;
  logic [20:0] leds0, leds1, leds2;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seg7_bcd_display #(.WIDTH(8), .DIGITS(3), .ACTIVE_LOW(1), .BLANK_LEADING(1)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid0), .in_data(in_data0),
    .in_ready(rdy0), .leds(leds0), .done(done0), .overflow(ovf0));

  seg7_bcd_display #(.WIDTH(8), .DIGITS(3), .ACTIVE_LOW(0), .BLANK_LEADING(0)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid0), .in_data(in_data0),
    .in_ready(rdy1), .leds(leds1), .done(done1), .overflow(ovf1));

  seg7_bcd_display #(.WIDTH(10), .DIGITS(3), .ACTIVE_LOW(1), .BLANK_LEADING(1)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_data(in_data2),
    .in_ready(rdy2), .leds(leds2), .done(done2), .overflow(ovf2));

  // Decimal display model: digits by division, blanking by magnitude.
  logic [6:0] seg_tab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                               7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};
  int cfg_w  [3] = '{8, 8, 10};
  int cfg_al [3] = '{1, 0, 1};
  int cfg_bl [3] = '{1, 0, 1};

  function automatic logic [20:0] exp_leds(input int v, input int al, input int bl);
    logic [20:0] r;
    logic [6:0]  p;
    int          p10;
    r   = '0;
    p10 = 1;
    for (int d = 0; d < 3; d++) begin
      if (v > 999)                         p = 7'b1000000;
      else if (bl != 0 && d > 0 && v < p10) p = 7'b0000000;
      else                                 p = seg_tab[(v / p10) % 10];
      if (al != 0) p = ~p;
      r[7*d +: 7] = p;
      p10 = p10 * 10;
    end
    return r;
  endfunction

  int          m_cnt  [3];
  int          m_val  [3];
  logic [20:0] m_leds [3];
  logic        m_ovf  [3];
  logic        m_done [3];

  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        m_cnt[i]  <= 0;
        m_leds[i] <= (cfg_al[i] != 0) ? 21'h1FFFFF : 21'h0;
        m_ovf[i]  <= 1'b0;
        m_done[i] <= 1'b0;
      end else begin
        m_done[i] <= 1'b0;
        if (m_cnt[i] == 0) begin
          if ((i == 2) ? in_valid2 : in_valid0) begin
            m_cnt[i] <= cfg_w[i] + 1;
            m_val[i] <= (i == 2) ? int'(in_data2) : int'(in_data0);
          end
        end else begin
          m_cnt[i] <= m_cnt[i] - 1;
          if (m_cnt[i] == 1) begin
            m_leds[i] <= exp_leds(m_val[i], cfg_al[i], cfg_bl[i]);
            m_ovf[i]  <= (m_val[i] > 999);
            m_done[i] <= 1'b1;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: timed out, got no event expected one (cycle %0d)", nm, cyc);
  endtask

  task automatic cmp_dut(input int i, input logic r, input logic d, input logic o,
                         input logic [20:0] l);
    chk($sformatf("in_ready%0d", i), r, m_cnt[i] == 0);
    chk($sformatf("done%0d", i), d, m_done[i]);
    chk($sformatf("overflow%0d", i), o, m_ovf[i]);
    chk($sformatf("leds%0d", i), l, m_leds[i]);
  endtask

  always @(negedge clk) begin
    cmp_dut(0, rdy0, done0, ovf0, leds0);
    cmp_dut(1, rdy1, done1, ovf1, leds1);
    cmp_dut(2, rdy2, done2, ovf2, leds2);
  end

  task automatic send(input int which, input int v);
    int n;
    n = 0;
    @(negedge clk);
    while (!((which == 2) ? rdy2 : rdy0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) timeout_fail("send_ready");
    if (which == 2) begin
      in_data2  = v[9:0];
      in_valid2 = 1'b1;
    end else begin
      in_data0  = v[7:0];
      in_valid0 = 1'b1;
    end
    @(posedge clk);
    #1;
    in_valid0 = 1'b0;
    in_valid2 = 1'b0;
  endtask

  task automatic wait_done(input int which);
    bit found;
    found = 1'b0;
    for (int n = 0; n < 60 && !found; n++) begin
      @(negedge clk);
      if ((which == 2) ? done2 : done0) found = 1'b1;
    end
    if (!found) timeout_fail("wait_done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ndone;
    int last_acc;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_leds0", leds0, 21'h1FFFFF);
    chk("rst_leds1", leds1, 21'h000000);
    chk("rst_leds2", leds2, 21'h1FFFFF);
    chk("rst_ready0", rdy0, 1'b1);
    chk("rst_done0", done0, 1'b0);
    chk("rst_ovf0", ovf0, 1'b0);

    // 245: busy window and first-result latency
    send(0, 245);
    n = 0;
    ndone = 0;
    while (n < 30) begin
      @(negedge clk);
      if (done0) ndone++;
      if (rdy0) break;
      n++;
    end
    chk("busy_cycles_245", n, 9);
    chk("done_at_ready_245", done0, 1'b1);
    chk("done_early_245", ndone, 1);
    chk("leds0_245", leds0, {7'h24, 7'h19, 7'h12});
    chk("leds1_245", leds1, {7'h5B, 7'h66, 7'h6D});
    chk("ovf0_245", ovf0, 1'b0);

    // leading blanking vs. zero-padded
    send(0, 0);
    wait_done(0);
    chk("leds0_0", leds0, {7'h7F, 7'h7F, 7'h40});
    chk("leds1_0", leds1, {7'h3F, 7'h3F, 7'h3F});
    send(0, 7);
    wait_done(0);
    chk("leds0_7", leds0, {7'h7F, 7'h7F, 7'h78});
    chk("leds1_7", leds1, {7'h3F, 7'h3F, 7'h07});
    send(0, 40);
    wait_done(0);
    chk("leds0_40", leds0, {7'h7F, 7'h19, 7'h40});
    chk("leds1_40", leds1, {7'h3F, 7'h66, 7'h3F});

    // overflow boundary on the 10-bit instance
    send(2, 1000);
    wait_done(2);
    chk("leds2_1000", leds2, {7'h3F, 7'h3F, 7'h3F});
    chk("ovf2_1000", ovf2, 1'b1);
    chk("leds0_hold", leds0, {7'h7F, 7'h19, 7'h40});
    send(2, 999);
    wait_done(2);
    chk("leds2_999", leds2, {7'h10, 7'h10, 7'h10});
    chk("ovf2_999", ovf2, 1'b0);

    // in_valid held with changing data while busy
    send(0, 123);
    in_valid0 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      in_data0 = 8'(k * 37 + 11);
    end
    @(negedge clk);
    in_valid0 = 1'b0;
    wait_done(0);
    chk("leds0_123", leds0, {7'h79, 7'h24, 7'h30});
    chk("leds1_123", leds1, {7'h06, 7'h5B, 7'h4F});

    // reset in the middle of a conversion
    send(0, 200);
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    chk("midrst_leds0", leds0, 21'h1FFFFF);
    chk("midrst_done0", done0, 1'b0);
    reset = 1'b0;
    ndone = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done0) ndone++;
    end
    chk("midrst_no_done", ndone, 0);
    chk("midrst_leds_after", leds0, 21'h1FFFFF);
    send(0, 56);
    wait_done(0);
    chk("leds0_56", leds0, {7'h7F, 7'h12, 7'h02});

    // back-to-back accepts over the full 8-bit range
    last_acc = 0;
    in_data0  = 8'd0;
    in_valid0 = 1'b1;
    for (int v = 0; v < 256; v++) begin
      in_data0 = 8'(v);
      n = 0;
      @(negedge clk);
      while (!rdy0 && n < 40) begin
        @(negedge clk);
        n++;
      end
      if (n >= 40) timeout_fail("b2b_ready");
      @(posedge clk);
      #1;
      if (v > 0) chk("b2b_gap", cyc - last_acc, 10);
      last_acc = cyc;
    end
    in_valid0 = 1'b0;
    wait_done(0);
    chk("leds0_255", leds0, {7'h24, 7'h12, 7'h12});
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
